// File: rtl/trap_pkg.sv
// Shared trap definitions: cause codes, sequencer states, handler vector lookup.
package trap_pkg;

  localparam logic [3:0] CAUSE_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd1;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd2;
  localparam logic [3:0] CAUSE_LADDR_MISALIGN = 4'd3;

  localparam logic [31:0] DEFAULT_TRAP_OFS = 32'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } trap_state_t;

  // Causes outside the implemented set fall through to the default trap slot.
  function automatic logic [31:0] vector_addr(input logic [31:0] base, input logic [3:0] cause);
    if (cause <= CAUSE_LADDR_MISALIGN)
      return base + {26'd0, cause, 2'b00};
    else
      return base + DEFAULT_TRAP_OFS;
  endfunction

endpackage

// File: rtl/trap_cause_encoder.sv
// Fixed-priority exception cause encoder, lowest bit wins.
// Combinational, zero latency; no flow control.
module trap_cause_encoder
  import trap_pkg::*;
(
  input  logic [3:0] req,
  output logic       any,
  output logic [3:0] cause
);

  always_comb begin
    any   = |req;
    cause = CAUSE_IADDR_MISALIGN;
    if (req[0])      cause = CAUSE_IADDR_MISALIGN;
    else if (req[1]) cause = CAUSE_ILLEGAL;
    else if (req[2]) cause = CAUSE_BREAKPOINT;
    else if (req[3]) cause = CAUSE_LADDR_MISALIGN;
  end

endmodule

// File: rtl/trap_controller.sv
// Exception sequencer: capture CSRs, flush, redirect to handler, mret return, double-fault halt.
// Entry latency FLUSH_CYCLES+1; pipeline is held via flush/stall, all outputs registered.
module trap_controller
  import trap_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  exc_req,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [3:0]  mcause,
  output logic [31:0] mtval,
  output logic        in_handler,
  output logic        fatal
);

  trap_state_t state;
  logic [2:0]  cnt;
  logic        enc_any;
  logic [3:0]  enc_cause;

  trap_cause_encoder u_enc (
    .req   (exc_req),
    .any   (enc_any),
    .cause (enc_cause)
  );

  // Outputs are assigned for the state being entered, so each is a pure register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= 3'd0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      mepc           <= 32'd0;
      mcause         <= 4'd0;
      mtval          <= 32'd0;
      in_handler     <= 1'b0;
      fatal          <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (enc_any) begin
            mcause <= enc_cause;
            mepc   <= exc_pc;
            mtval  <= exc_tval;
            cnt    <= 3'(FLUSH_CYCLES);
            flush  <= 1'b1;
            stall  <= 1'b1;
            state  <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= vector_addr(VEC_BASE, mcause);
            state          <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          stall      <= 1'b0;
          in_handler <= 1'b1;
          state      <= ST_HANDLER;
        end
        ST_HANDLER: begin
          // A trap inside the handler is unrecoverable and beats a concurrent mret.
          if (enc_any) begin
            in_handler <= 1'b0;
            flush      <= 1'b1;
            stall      <= 1'b1;
            fatal      <= 1'b1;
            state      <= ST_HALT;
          end else if (mret_req) begin
            in_handler     <= 1'b0;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc + 32'd4;
            state          <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          flush <= 1'b0;
          state <= ST_IDLE;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          flush      <= 1'b0;
          stall      <= 1'b0;
          in_handler <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: vector table of trap entries/returns plus corner sequences.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [3:0]  exc_req, exc_req2;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_req;
  logic        flush, stall, redirect_valid, in_handler, fatal;
  logic [31:0] redirect_pc, mepc, mtval;
  logic [3:0]  mcause;
  logic        flush2, stall2, rv2, ih2, fatal2;
  logic [31:0] rpc2, mepc2, mtval2;
  logic [3:0]  mcause2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  trap_controller #(.FLUSH_CYCLES(2), .VEC_BASE(32'h80)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .flush(flush), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .in_handler(in_handler), .fatal(fatal)
  );

  trap_controller #(.FLUSH_CYCLES(4), .VEC_BASE(32'h80)) dut4 (
    .clk(clk), .rst(rst2), .exc_req(exc_req2), .exc_pc(32'h500), .exc_tval(32'h5),
    .mret_req(1'b0), .flush(flush2), .stall(stall2), .redirect_valid(rv2),
    .redirect_pc(rpc2), .mepc(mepc2), .mcause(mcause2), .mtval(mtval2),
    .in_handler(ih2), .fatal(fatal2)
  );

  typedef struct packed {
    logic        flush;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ih;
    logic        fatal;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [3:0]  cause;
    logic [31:0] vec;
    logic [31:0] ret;
    bit          noise;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[5];

  function automatic exp_t mk(logic f, logic s, logic rv, logic [31:0] rpc, logic ih, logic ft);
    exp_t e;
    e.flush = f; e.stall = s; e.rv = rv; e.rpc = rpc; e.ih = ih; e.fatal = ft;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample #1 after the edge and compare against the oldest scoreboard entry.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("flush", 32'(flush), 32'(e.flush));
      chk("stall", 32'(stall), 32'(e.stall));
      chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
      chk("in_handler", 32'(in_handler), 32'(e.ih));
      chk("fatal", 32'(fatal), 32'(e.fatal));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && expq.size() > 0; i++) step();
    if (expq.size() > 0) begin
      chk("scoreboard_drain", 32'(expq.size()), 32'd0);
      expq.delete();
    end
  endtask

  // Enter the handler; optional noise on exc_* while flushing must be ignored.
  task automatic enter(input vec_t v);
    exc_req = v.req; exc_pc = v.pc; exc_tval = v.tval;
    for (int i = 0; i < 2; i++) expq.push_back(mk(1, 1, 0, 0, 0, 0));
    expq.push_back(mk(0, 1, 1, v.vec, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 1, 0));
    step();
    if (v.noise) begin
      exc_req = 4'b0001; exc_pc = 32'hBAD0; exc_tval = 32'hBAD1;
    end else begin
      exc_req = 4'b0000;
    end
    drain();
    exc_req = 4'b0000;
    chk("mcause", 32'(mcause), 32'(v.cause));
    chk("mepc", mepc, v.pc);
    chk("mtval", mtval, v.tval);
  endtask

  task automatic do_return(input logic [31:0] ret);
    mret_req = 1'b1;
    expq.push_back(mk(1, 0, 1, ret, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    mret_req = 1'b0;
    drain();
  endtask

  initial begin
    tbl[0] = '{4'b0010, 32'h100,       32'hDEAD_BEEF, 4'd1, 32'h84, 32'h104, 1'b0};
    tbl[1] = '{4'b1100, 32'h300,       32'h0000_1234, 4'd2, 32'h88, 32'h304, 1'b1};
    tbl[2] = '{4'b1111, 32'h200,       32'h0,         4'd0, 32'h80, 32'h204, 1'b0};
    tbl[3] = '{4'b1000, 32'hFFFF_FFFC, 32'h0000_CAFE, 4'd3, 32'h8C, 32'h0,   1'b1};
    tbl[4] = '{4'b0100, 32'h40,        32'h1,         4'd2, 32'h88, 32'h44,  1'b0};

    rst = 1'b1; rst2 = 1'b1;
    exc_req = 4'b0; exc_req2 = 4'b0; exc_pc = 32'h0; exc_tval = 32'h0; mret_req = 1'b0;
    step();
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    chk("rst_mepc", mepc, 32'h0);
    chk("rst_mcause", 32'(mcause), 32'h0);
    chk("rst_mtval", mtval, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0; rst2 = 1'b0;

    // mret while idle must not redirect
    mret_req = 1'b1;
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    step();
    mret_req = 1'b0;

    for (int i = 0; i < 5; i++) begin
      enter(tbl[i]);
      do_return(tbl[i].ret);
    end

    // Double fault with concurrent mret: halt wins, CSRs keep first trap.
    enter(tbl[0]);
    exc_req = 4'b1000; mret_req = 1'b1;
    for (int i = 0; i < 4; i++) expq.push_back(mk(1, 1, 0, 0, 0, 1));
    step();
    exc_req = 4'b0; mret_req = 1'b0;
    drain();
    chk("halt_mcause", 32'(mcause), 32'd1);
    chk("halt_mepc", mepc, 32'h100);
    rst = 1'b1;
    expq.push_back(mk(0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    chk("post_halt_mcause", 32'(mcause), 32'd0);

    // Reset in the first flush cycle of the FLUSH_CYCLES=4 instance.
    exc_req2 = 4'b0010;
    step();
    exc_req2 = 4'b0;
    chk("f4_flush_first", 32'(flush2), 32'd1);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    chk("f4_rst_flush", 32'(flush2), 32'd0);
    chk("f4_rst_stall", 32'(stall2), 32'd0);
    chk("f4_rst_rv", 32'(rv2), 32'd0);
    chk("f4_rst_rpc", rpc2, 32'd0);
    chk("f4_rst_mepc", mepc2, 32'd0);
    chk("f4_rst_mcause", 32'(mcause2), 32'd0);
    chk("f4_rst_mtval", mtval2, 32'd0);
    chk("f4_rst_ih", 32'(ih2), 32'd0);
    chk("f4_rst_fatal", 32'(fatal2), 32'd0);
    exc_req2 = 4'b0100;
    step();
    exc_req2 = 4'b0;
    for (int i = 0; i < 4; i++) begin
      chk("f4_flush", 32'(flush2), 32'd1);
      chk("f4_rv_low", 32'(rv2), 32'd0);
      step();
    end
    chk("f4_flush_done", 32'(flush2), 32'd0);
    chk("f4_rv", 32'(rv2), 32'd1);
    chk("f4_rpc", rpc2, 32'h88);
    step();
    chk("f4_rv_single", 32'(rv2), 32'd0);
    chk("f4_in_handler", 32'(ih2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer for the exception path of the 5-stage pipeline. Collects per-cause exception requests, selects one by fixed priority, latches the trap CSR state (mepc/mcause/mtval), flushes the pipeline for a configurable number of cycles, then redirects fetch to the vectored handler address. While the handler runs, it tracks handler residency, returns to `mepc + 4` on `mret`, and escalates a nested exception to a sticky fatal halt. It sits beside the hazard unit and drives the PC-select mux and all stage flush/stall lines.

## Interface
- `FLUSH_CYCLES`, 2, number of cycles `flush` is held (legal range 1..7).
- `VEC_BASE`, 32'h0000_0080, handler base; handler address = `VEC_BASE + 4*cause`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exc_req`  in  4  one bit per cause: [0] instruction address misaligned, [1] illegal instruction, [2] breakpoint, [3] load address misaligned.
- `exc_pc`  in  32  PC of the faulting instruction; valid when any `exc_req` bit is set.
- `exc_tval`  in  32  faulting address or instruction word.
- `mret_req`  in  1  `mret` retiring in MEM.
- `flush`  out  1  flush IF/ID/EX/MEM pipeline registers.
- `stall`  out  1  freeze PC and pipeline registers.
- `redirect_valid`  out  1  single-cycle PC override strobe.
- `redirect_pc`  out  32  target PC; meaningful only while `redirect_valid` is high.
- `mepc`  out  32  latched exception PC.
- `mcause`  out  4  latched cause code.
- `mtval`  out  32  latched trap value.
- `in_handler`  out  1  high while the handler executes.
- `fatal`  out  1  sticky double-fault indicator.

## Operation
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT.
- IDLE: `exc_req != 0` captures the trap:
  - `mcause` = lowest set bit index (priority 0 > 1 > 2 > 3);
  - `mepc` = `exc_pc`; `mtval` = `exc_tval`;
  - flush counter is loaded with `FLUSH_CYCLES`; next state is FLUSH.
  - `mret_req` in IDLE is ignored.
- FLUSH: `flush = 1`, `stall = 1`; counter decrements each cycle; the state exits to REDIRECT on the cycle the counter reaches 1.
- REDIRECT: `redirect_valid = 1`, `redirect_pc = VEC_BASE + {mcause, 2'b00}`, `stall = 1`. The next state is HANDLER.
  - Cause values 4..15 cannot be produced by the priority encoder. The vector function still maps them to `VEC_BASE + 32'h10` (default trap).
- HANDLER: `in_handler = 1`, no stall.
  - `exc_req != 0` goes to HALT and sets `fatal`; CSRs are not overwritten.
  - Otherwise, `mret_req` goes to RETURN.
  - Exception and `mret_req` in the same cycle: the exception wins and the block goes to HALT.
- RETURN: `flush = 1`, `redirect_valid = 1`, `redirect_pc = mepc + 4` (32-bit wrap: 32'hFFFF_FFFC returns 0). The next state is IDLE. `in_handler` deasserts in this cycle.
- HALT: `stall = 1`, `flush = 1`, `fatal = 1`. Only `rst` exits this state.
- `exc_req` is ignored in FLUSH, REDIRECT and RETURN, because the pipeline is being flushed.
- `mepc`, `mcause` and `mtval` hold their values until the next capture in IDLE.

## Timing
- Reset (any state, including mid-flush): state is IDLE. The following outputs are 0: `flush`, `stall`, `redirect_valid`, `redirect_pc`, `mepc`, `mcause`, `mtval`, `in_handler`, `fatal`, and the counter.
- All outputs are registered-state decodes (Moore). No input-to-output combinational path exists.
- Exception sampled at edge N gives:
  - `flush`/`stall` high for cycles N+1 .. N+FLUSH_CYCLES;
  - `redirect_valid` high in cycle N+FLUSH_CYCLES+1;
  - `in_handler` high from N+FLUSH_CYCLES+2.
- Trap entry latency is `FLUSH_CYCLES + 1` cycles; `redirect_valid` is always exactly 1 cycle wide.
- `mret_req` sampled at edge M gives RETURN in cycle M+1 and IDLE in M+2.
- A new exception at edge M+2 is accepted normally.

## Structure
- Shared package `trap_pkg` holds:
  - cause encodings (`CAUSE_IADDR_MISALIGN` = 0, `CAUSE_ILLEGAL` = 1, `CAUSE_BREAKPOINT` = 2, `CAUSE_LADDR_MISALIGN` = 3);
  - the state enum;
  - the default-trap offset 32'h10;
  - a `vector_addr(base, cause)` function, which the handler-address lookup elsewhere in the design also uses.
- One sub-module, `trap_cause_encoder`: combinational 4-bit priority encoder producing `any` and `cause[3:0]`.
- Everything else (FSM, counter, CSR registers) lives in `trap_controller`.

## Test plan
- Illegal entry, FLUSH_CYCLES = 2: `exc_req = 4'b0010`, `exc_pc = 32'h100`, `exc_tval = 32'hDEAD_BEEF`.
  - Required: `flush` high for 2 cycles, then `redirect_valid` with `redirect_pc = 32'h84`.
  - `mcause = 1`, `mepc = 32'h100`, `mtval = 32'hDEAD_BEEF`.
- Priority: `exc_req = 4'b1100` gives `mcause = 2` and `redirect_pc = 32'h88`. Then `exc_req = 4'b1111` (from a fresh IDLE) gives `mcause = 0` and `redirect_pc = 32'h80`.
- Return: in HANDLER with `mepc = 32'h200`, pulse `mret_req`.
  - Required: 1 cycle of `flush` + `redirect_valid` with `redirect_pc = 32'h204`; IDLE on the following cycle.
  - Repeat with `mepc = 32'hFFFF_FFFC`: `redirect_pc = 0`.
- Double fault: in HANDLER, drive `exc_req = 4'b1000` together with `mret_req`.
  - Required: HALT, `fatal = 1`, `stall = 1`, `mcause` unchanged.
  - `fatal` stays high until `rst`.
- Ignored inputs: `mret_req` in IDLE causes no redirect. `exc_req` during FLUSH/REDIRECT does not change `mcause`/`mepc`.
- Reset mid-flush: assert `rst` in the first FLUSH cycle (FLUSH_CYCLES = 4). All outputs must be 0 in the next cycle. A fresh exception afterwards must give the full 4-cycle flush.
